// File: rtl/prf_operand_read_pkg.sv
// prf_operand_read_pkg: shared constants and packet types for the register-read stage
package prf_operand_read_pkg;
    localparam int N_ISSUE    = 3;
    localparam int N_WB       = 7;
    localparam int N_PHYS_REG = 64;
    localparam int PREG_W     = 6;
    localparam int XLEN       = 32;
    localparam int PAYLOAD_W  = 64;

    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_e;

    typedef struct packed {
        logic                 valid;
        logic [PREG_W-1:0]    src1;
        logic [PREG_W-1:0]    src2;
        logic [PAYLOAD_W-1:0] payload;
    } issue_rd_packet_t;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      src1_val;
        logic [XLEN-1:0]      src2_val;
        logic [PAYLOAD_W-1:0] payload;
    } ex_opnd_packet_t;

    typedef ex_opnd_packet_t [N_ISSUE-1:0] ex_bundle_t;
endpackage

// File: rtl/operand_bypass_mux.sv
// operand_bypass_mux: resolves one source preg from the PRF with same-cycle writeback forwarding
module operand_bypass_mux
    import prf_operand_read_pkg::*;
(
    input  logic [PREG_W-1:0]          src,
    input  logic [N_PHYS_REG*XLEN-1:0] phys_reg,
    input  logic [N_WB*PREG_W-1:0]     wb_idx,
    input  logic [N_WB*XLEN-1:0]       wb_value,
    output logic [XLEN-1:0]            value
);
    // ascending scan so the highest matching port wins, like the PRF write priority
    always_comb begin
        value = phys_reg[src*XLEN +: XLEN];
        for (int k = 0; k < N_WB; k++)
            if (wb_idx[k*PREG_W +: PREG_W] == src) value = wb_value[k*XLEN +: XLEN];
        if (src == '0) value = '0;
    end
endmodule

// File: rtl/prf_operand_read.sv
// prf_operand_read: register-read stage with writeback bypass and an output register plus skid entry
module prf_operand_read
    import prf_operand_read_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [N_PHYS_REG*XLEN-1:0]  phys_reg,
    input  logic [N_WB*PREG_W-1:0]      wb_idx,
    input  logic [N_WB*XLEN-1:0]        wb_value,
    input  logic [N_ISSUE-1:0]          issue_valid,
    input  logic [N_ISSUE*PREG_W-1:0]   issue_src1,
    input  logic [N_ISSUE*PREG_W-1:0]   issue_src2,
    input  logic [N_ISSUE*PAYLOAD_W-1:0] issue_payload,
    output logic                        issue_ready,
    input  logic                        ex_ready,
    output logic [N_ISSUE-1:0]          ex_valid,
    output logic [N_ISSUE*XLEN-1:0]     ex_src1_val,
    output logic [N_ISSUE*XLEN-1:0]     ex_src2_val,
    output logic [N_ISSUE*PAYLOAD_W-1:0] ex_payload
);
    occ_e       state_q, state_d;
    ex_bundle_t rd, out_q, out_d, skid_q, skid_d;
    logic       issue_ready_q, accept, retire;

    for (genvar i = 0; i < N_ISSUE; i++) begin : g_slot
        issue_rd_packet_t iss;
        logic [XLEN-1:0]  v1, v2;
        assign iss = '{valid: issue_valid[i], src1: issue_src1[i*PREG_W +: PREG_W],
                       src2: issue_src2[i*PREG_W +: PREG_W], payload: issue_payload[i*PAYLOAD_W +: PAYLOAD_W]};
        operand_bypass_mux u_src1 (.src(iss.src1), .phys_reg, .wb_idx, .wb_value, .value(v1));
        operand_bypass_mux u_src2 (.src(iss.src2), .phys_reg, .wb_idx, .wb_value, .value(v2));
        assign rd[i] = '{valid: iss.valid, src1_val: v1, src2_val: v2, payload: iss.payload};
        assign ex_valid[i] = out_q[i].valid;
        assign ex_src1_val[i*XLEN +: XLEN] = out_q[i].src1_val;
        assign ex_src2_val[i*XLEN +: XLEN] = out_q[i].src2_val;
        assign ex_payload[i*PAYLOAD_W +: PAYLOAD_W] = out_q[i].payload;
    end

    assign issue_ready = issue_ready_q;
    assign accept = |issue_valid && issue_ready_q;
    assign retire = |ex_valid && ex_ready;

    always_comb begin
        state_d = state_q;
        out_d = out_q;
        skid_d = skid_q;
        if (squash) begin
            state_d = OCC_EMPTY;
            out_d = '0;
            skid_d = '0;
        end else begin
            case (state_q)
                OCC_EMPTY: if (accept) begin
                    out_d = rd;
                    state_d = OCC_ONE;
                end
                OCC_ONE: if (accept && retire) out_d = rd;
                else if (accept) begin
                    skid_d = rd;
                    state_d = OCC_FULL;
                end else if (retire) begin
                    out_d = '0;
                    state_d = OCC_EMPTY;
                end
                OCC_FULL: if (retire) begin
                    out_d = skid_q;
                    skid_d = '0;
                    state_d = OCC_ONE;
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
            out_q <= '0;
            skid_q <= '0;
            issue_ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q <= out_d;
            skid_q <= skid_d;
            issue_ready_q <= state_d != OCC_FULL;
        end
    end
endmodule

// File: tb/tb_prf_operand_read.sv
// tb_prf_operand_read: directed self-checking bench for the register-read stage
module tb_prf_operand_read;
    import prf_operand_read_pkg::*;

    logic clock = 1'b0, reset, squash, ex_ready, issue_ready;
    logic [N_PHYS_REG*XLEN-1:0]   phys_reg;
    logic [N_WB*PREG_W-1:0]       wb_idx;
    logic [N_WB*XLEN-1:0]         wb_value;
    logic [N_ISSUE-1:0]           issue_valid, ex_valid;
    logic [N_ISSUE*PREG_W-1:0]    issue_src1, issue_src2;
    logic [N_ISSUE*PAYLOAD_W-1:0] issue_payload, ex_payload;
    logic [N_ISSUE*XLEN-1:0]      ex_src1_val, ex_src2_val;
    int total = 0, bad = 0;

    prf_operand_read dut (
        .clock(clock), .reset(reset), .squash(squash), .phys_reg(phys_reg),
        .wb_idx(wb_idx), .wb_value(wb_value), .issue_valid(issue_valid),
        .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_payload(issue_payload),
        .issue_ready(issue_ready), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_src1_val(ex_src1_val), .ex_src2_val(ex_src2_val), .ex_payload(ex_payload)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [5:0] s1, input logic [5:0] s2, input logic [63:0] pl);
        issue_src1[i*PREG_W +: PREG_W] = s1;
        issue_src2[i*PREG_W +: PREG_W] = s2;
        issue_payload[i*PAYLOAD_W +: PAYLOAD_W] = pl;
    endtask

    task automatic set_wb(input int k, input logic [5:0] idx, input logic [31:0] val);
        wb_idx[k*PREG_W +: PREG_W] = idx;
        wb_value[k*XLEN +: XLEN] = val;
    endtask

    function automatic logic [31:0] o1(input int i);
        return ex_src1_val[i*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] o2(input int i);
        return ex_src2_val[i*XLEN +: XLEN];
    endfunction

    function automatic logic [63:0] pl(input int i);
        return ex_payload[i*PAYLOAD_W +: PAYLOAD_W];
    endfunction

    initial begin
        reset = 1'b1; squash = 1'b0; ex_ready = 1'b0;
        wb_idx = '0; wb_value = '0; issue_valid = '0;
        issue_src1 = '0; issue_src2 = '0; issue_payload = '0;
        for (int r = 0; r < N_PHYS_REG; r++) phys_reg[r*XLEN +: XLEN] = 32'h100 + r;
        phys_reg[0 +: XLEN] = 32'hDEAD;
        phys_reg[5*XLEN +: XLEN] = 32'hAA;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_valid", ex_valid, 0);
        chk("rst_src1", ex_src1_val, 0);
        chk("rst_payload", ex_payload, 0);
        chk("rst_ready", issue_ready, 1);

        // plain read, preg 0 reads zero despite a nonzero array entry
        ex_ready = 1'b1;
        set_slot(0, 5, 0, 64'h1111);
        issue_valid = 3'b001;
        step();
        issue_valid = '0;
        chk("t1_valid", ex_valid, 3'b001);
        chk("t1_src1", o1(0), 32'hAA);
        chk("t1_src2", o2(0), 0);
        chk("t1_payload", pl(0), 64'h1111);
        chk("t1_ready", issue_ready, 1);
        step();
        chk("t1_retired", ex_valid, 0);

        // bypass priority and no bypass onto preg 0
        set_wb(0, 0, 32'hFF);
        set_wb(2, 5, 32'hBB);
        set_wb(3, 9, 32'h99);
        set_wb(6, 5, 32'hCC);
        set_slot(0, 5, 0, 64'h2222);
        set_slot(1, 7, 9, 64'h3333);
        issue_valid = 3'b011;
        step();
        issue_valid = '0; wb_idx = '0; wb_value = '0;
        chk("t2_valid", ex_valid, 3'b011);
        chk("t2_hi_port", o1(0), 32'hCC);
        chk("t2_zero", o2(0), 0);
        chk("t2_array", o1(1), 32'h107);
        chk("t2_bypass", o2(1), 32'h99);
        chk("t2_payload", pl(1), 64'h3333);
        step();

        // fill skid, hold C off while full, drain in order A, B, C
        ex_ready = 1'b0;
        set_slot(0, 1, 0, 64'hA);
        issue_valid = 3'b001;
        step();
        chk("t3_a_valid", ex_valid, 3'b001);
        chk("t3_one_ready", issue_ready, 1);
        set_slot(2, 2, 0, 64'hB);
        issue_valid = 3'b100;
        step();
        chk("t3_full_ready", issue_ready, 0);
        chk("t3_full_a", pl(0), 64'hA);
        set_slot(1, 3, 0, 64'hC);
        issue_valid = 3'b010;
        step();
        chk("t3_stall_valid", ex_valid, 3'b001);
        chk("t3_stall_ready", issue_ready, 0);
        ex_ready = 1'b1;
        step();
        chk("t3_b_valid", ex_valid, 3'b100);
        chk("t3_b_payload", pl(2), 64'hB);
        chk("t3_b_src1", o1(2), 32'h102);
        chk("t3_b_ready", issue_ready, 1);
        step();
        issue_valid = '0;
        chk("t3_c_valid", ex_valid, 3'b010);
        chk("t3_c_payload", pl(1), 64'hC);
        chk("t3_c_src1", o1(1), 32'h103);
        step();
        chk("t3_empty", ex_valid, 0);
        chk("t3_empty_ready", issue_ready, 1);

        // squash while full drops both buffered bundles and the concurrent issue
        ex_ready = 1'b0;
        set_slot(0, 1, 0, 64'hA2);
        issue_valid = 3'b001;
        step();
        set_slot(0, 2, 0, 64'hB2);
        step();
        chk("t4_full", issue_ready, 0);
        set_slot(0, 4, 4, 64'hD0);
        set_slot(1, 4, 4, 64'hD1);
        set_slot(2, 4, 4, 64'hD2);
        issue_valid = 3'b111;
        squash = 1'b1;
        step();
        squash = 1'b0; issue_valid = '0;
        chk("t4_valid", ex_valid, 0);
        chk("t4_ready", issue_ready, 1);
        ex_ready = 1'b1;
        step();
        chk("t4_nothing", ex_valid, 0);

        // reset mid-flight discards the held bundle
        ex_ready = 1'b0;
        set_slot(0, 6, 7, 64'hE);
        issue_valid = 3'b001;
        step();
        chk("t5_one", ex_valid, 3'b001);
        issue_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_valid", ex_valid, 0);
        chk("t5_src1", ex_src1_val, 0);
        chk("t5_src2", ex_src2_val, 0);
        chk("t5_payload", ex_payload, 0);
        chk("t5_ready", issue_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
